// File: rtl/apb_uart_fifo.sv
// APB-slave 8N1 UART: TX/RX byte FIFOs, programmable baud divisor, 16x oversampled
// receiver, sticky error flags and a maskable, registered level interrupt.

module apb_uart_fifo_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  wdata,
  output logic [7:0]  head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  // NOTE: the storage array is deliberately not reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head  = mem[rptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

module apb_uart_fifo #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic              pclk,
  input  logic              prstn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic              uart_rx,
  output logic              uart_tx,
  output logic              uart_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] REG_DATA = 2'd0, REG_STATUS = 2'd1, REG_CTRL = 2'd2, REG_IE = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  logic             wr_stb, rd_stb;
  logic [1:0]       widx;
  logic             tx_en, rx_en;
  logic [DIV_W-1:0] div;
  logic [2:0]       ie;
  logic             rx_ovr, frm_err, tx_ovf;
  logic [2:0]       sts_clr;

  logic             tx_push, tx_pop, tx_full, tx_empty, tx_busy, tx_tick, tx_bit_end;
  logic [7:0]       tx_head, tx_shr;
  logic [AW:0]      tx_count;
  uart_state_t      tx_state;
  logic [DIV_W-1:0] tx_bcnt;
  logic [3:0]       tx_tcnt;
  logic [2:0]       tx_bit;

  logic             rx_push, rx_pop, rx_full, rx_empty, rx_tick, rx_bit_end;
  logic             rx_s1, rx_s2, rx_prev, rx_fall, rx_stop_end;
  logic [7:0]       rx_head, rx_shr;
  logic [AW:0]      rx_count;
  uart_state_t      rx_state;
  logic [DIV_W-1:0] rx_bcnt;
  logic [3:0]       rx_tcnt;
  logic [2:0]       rx_bit;

  logic             unused_bits;

  assign wr_stb  = psel && penable && pwrite;
  assign rd_stb  = psel && penable && !pwrite;
  assign widx    = paddr[3:2];
  assign pready  = 1'b1;
  assign pslverr = 1'b0;
  assign sts_clr = (wr_stb && widx == REG_STATUS) ? pwdata[7:5] : 3'b000;

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign tx_pop      = (tx_state == S_IDLE) && tx_en && !tx_empty;
  assign tx_push     = wr_stb && widx == REG_DATA && (!tx_full || tx_pop);
  assign rx_pop      = rd_stb && widx == REG_DATA && !rx_empty;
  assign rx_stop_end = rx_en && (rx_state == S_STOP) && rx_bit_end;
  assign rx_push     = rx_stop_end && rx_s2 && (!rx_full || rx_pop);

  apb_uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(pclk), .rst_n(prstn), .push(tx_push), .pop(tx_pop), .wdata(pwdata[7:0]),
    .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  apb_uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(pclk), .rst_n(prstn), .push(rx_push), .pop(rx_pop), .wdata(rx_shr),
    .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      case (widx)
        REG_DATA:   if (!rx_empty) prdata[7:0] = rx_head;
        REG_STATUS: prdata[15:0] = {8'(rx_count), tx_ovf, frm_err, rx_ovr, tx_busy,
                                    rx_empty, rx_full, tx_empty, tx_full};
        REG_CTRL: begin
          prdata[16 +: DIV_W] = div;
          prdata[1:0]         = {rx_en, tx_en};
        end
        default:    prdata[2:0] = ie;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      tx_en    <= 1'b0;
      rx_en    <= 1'b0;
      div      <= '0;
      ie       <= '0;
      rx_ovr   <= 1'b0;
      frm_err  <= 1'b0;
      tx_ovf   <= 1'b0;
      uart_irq <= 1'b0;
    end else begin
      if (wr_stb && widx == REG_CTRL) begin
        tx_en <= pwdata[0];
        rx_en <= pwdata[1];
        div   <= pwdata[16 +: DIV_W];
      end
      if (wr_stb && widx == REG_IE) ie <= pwdata[2:0];
      // A set event in the same cycle as a write-1-to-clear wins.
      rx_ovr  <= (rx_stop_end && rx_s2 && rx_full && !rx_pop) || (rx_ovr && !sts_clr[0]);
      frm_err <= (rx_stop_end && !rx_s2) || (frm_err && !sts_clr[1]);
      tx_ovf  <= (wr_stb && widx == REG_DATA && tx_full && !tx_pop) || (tx_ovf && !sts_clr[2]);
      uart_irq <= (ie[0] && !rx_empty) || (ie[1] && tx_empty && !tx_busy) ||
                  (ie[2] && (rx_ovr || frm_err || tx_ovf));
    end
  end

  assign tx_busy    = (tx_state != S_IDLE);
  assign tx_tick    = (tx_bcnt >= div);
  assign tx_bit_end = tx_tick && tx_tcnt == 4'd15;

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      tx_state <= S_IDLE;
      tx_bcnt  <= '0;
      tx_tcnt  <= '0;
      tx_bit   <= '0;
      tx_shr   <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_bcnt <= tx_tick ? '0 : tx_bcnt + 1'b1;
      if (tx_tick) tx_tcnt <= tx_tcnt + 1'b1;
      case (tx_state)
        S_IDLE: begin
          uart_tx <= 1'b1;
          if (tx_pop) begin
            tx_shr   <= tx_head;
            tx_bcnt  <= '0;
            tx_tcnt  <= '0;
            uart_tx  <= 1'b0;
            tx_state <= S_START;
          end
        end
        S_START: if (tx_bit_end) begin
          tx_state <= S_DATA;
          tx_bit   <= '0;
          uart_tx  <= tx_shr[0];
        end
        S_DATA: if (tx_bit_end) begin
          if (tx_bit == 3'd7) begin
            tx_state <= S_STOP;
            uart_tx  <= 1'b1;
          end else begin
            tx_shr  <= tx_shr >> 1;
            uart_tx <= tx_shr[1];
            tx_bit  <= tx_bit + 1'b1;
          end
        end
        default: if (tx_bit_end) tx_state <= S_IDLE;
      endcase
    end
  end

  assign rx_fall    = rx_prev && !rx_s2;
  assign rx_tick    = (rx_bcnt >= div);
  assign rx_bit_end = rx_tick && rx_tcnt == 4'd15;

  // The baud phase restarts on the start-bit edge so samples land mid-bit.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_bcnt  <= '0;
      rx_tcnt  <= '0;
      rx_bit   <= '0;
      rx_shr   <= '0;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_bcnt <= rx_tick ? '0 : rx_bcnt + 1'b1;
      if (rx_tick) rx_tcnt <= rx_tcnt + 1'b1;
      if (!rx_en) begin
        rx_state <= S_IDLE;
      end else begin
        case (rx_state)
          S_IDLE: if (rx_fall) begin
            rx_state <= S_START;
            rx_bcnt  <= '0;
            rx_tcnt  <= '0;
          end
          S_START: if (rx_tick && rx_tcnt == 4'd7) begin
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
            rx_tcnt  <= '0;
            rx_bit   <= '0;
          end
          S_DATA: if (rx_bit_end) begin
            rx_shr <= {rx_s2, rx_shr[7:1]};
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
          end
          default: if (rx_bit_end) rx_state <= S_IDLE;
        endcase
      end
    end
  end

  assign unused_bits = ^{paddr, pwdata, tx_count};
endmodule

// File: tb/tb_apb_uart_fifo.sv
// Self-checking bench for apb_uart_fifo: serial bit and received-byte scoreboards,
// register-level status checks, interrupt timing and reset behaviour.

module tb_apb_uart_fifo;
  localparam int DEPTH = 8;
  localparam logic [3:0] A_DATA = 4'h0, A_STATUS = 4'h4, A_CTRL = 4'h8, A_IE = 4'hC;

  logic        pclk = 1'b0, prstn = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [3:0]  paddr = '0;
  logic [31:0] pwdata = '0, prdata;
  logic        pready, pslverr, uart_rx, uart_tx, uart_irq;
  logic        loop_en = 1'b0, rx_drv = 1'b1;
  int          n_checks = 0, n_fails = 0;
  logic [7:0]  rx_exp[$];
  logic        tx_bits_exp[$];

  assign uart_rx = loop_en ? uart_tx : rx_drv;
  always #5 pclk = ~pclk;

  apb_uart_fifo dut (
    .pclk(pclk), .prstn(prstn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .uart_irq(uart_irq)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // All bus tasks are entered and left 1ns after a rising edge.
  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
    psel = 1'b1; pwrite = 1'b1; paddr = addr; pwdata = data; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] addr, output logic [31:0] data);
    psel = 1'b1; pwrite = 1'b0; paddr = addr; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    #1 data = prdata;
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  // Setup phase only: prdata is valid but no access completes, so nothing pops.
  task automatic apb_peek(input logic [3:0] addr, output logic [31:0] data);
    psel = 1'b1; pwrite = 1'b0; paddr = addr; penable = 1'b0;
    #1 data = prdata;
    psel = 1'b0;
  endtask

  // probe 1: rx_count latency window; probe 2: interrupt rise one cycle after the push.
  task automatic send_byte(input logic [7:0] b, input logic stop, input int div, input int probe);
    logic [9:0]  frame;
    logic [31:0] st;
    int          bit_len;
    bit          pushed, seen;
    frame   = {stop, b, 1'b0};
    bit_len = 16 * (div + 1);
    pushed  = 1'b0;
    seen    = 1'b0;
    for (int c = 0; c < 10 * bit_len; c++) begin
      rx_drv = frame[c / bit_len];
      if (probe == 1 && c == 153) begin
        apb_peek(A_STATUS, st);
        check("rx_lat_early", 32'(st[15:8]), 32'd0);
      end
      if (probe == 1 && c == 156) begin
        apb_peek(A_STATUS, st);
        check("rx_lat_late", 32'(st[15:8]), 32'd1);
      end
      if (probe == 2 && c >= 150 && !seen) begin
        apb_peek(A_STATUS, st);
        if (pushed) begin
          check("irq_rise", 32'(uart_irq), 32'd1);
          seen = 1'b1;
        end else if (!st[3]) begin
          pushed = 1'b1;
          check("irq_lag", 32'(uart_irq), 32'd0);
        end
      end
      @(posedge pclk); #1;
    end
    rx_drv = 1'b1;
    if (probe == 2) check("irq_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    logic [7:0]  lb [3];
    int          cyc;

    // Reset and idle
    repeat (3) @(posedge pclk); #1;
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_irq", 32'(uart_irq), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    prstn = 1'b1;
    @(posedge pclk); #1;
    apb_peek(A_STATUS, rd);
    check("rst_status", rd, 32'h0000_000A);

    // TX frame, div=0
    apb_write(A_CTRL, 32'h0000_0001);
    b = 8'hA5;
    tx_bits_exp.push_back(1'b0);
    for (int i = 0; i < 8; i++) tx_bits_exp.push_back(b[i]);
    tx_bits_exp.push_back(1'b1);
    apb_write(A_DATA, {24'h0, b});
    check("tx_lat_hold", 32'(uart_tx), 32'd1);
    @(posedge pclk); #1;
    check("tx_lat_fall", 32'(uart_tx), 32'd0);
    repeat (8) @(posedge pclk); #1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("tx_bit%0d", i), 32'(uart_tx), 32'(tx_bits_exp.pop_front()));
      if (i < 9) begin
        repeat (16) @(posedge pclk); #1;
      end
    end
    repeat (7) @(posedge pclk); #1;
    apb_peek(A_STATUS, rd);
    check("tx_busy_last", 32'(rd[4]), 32'd1);
    @(posedge pclk); #1;
    apb_peek(A_STATUS, rd);
    check("tx_done_status", rd, 32'h0000_000A);
    check("tx_idle_line", 32'(uart_tx), 32'd1);

    // RX loopback, div=3
    loop_en = 1'b1;
    apb_write(A_CTRL, 32'h0003_0003);
    lb = '{8'h3C, 8'hFF, 8'h00};
    for (int i = 0; i < 3; i++) begin
      rx_exp.push_back(lb[i]);
      apb_write(A_DATA, {24'h0, lb[i]});
    end
    cyc = 0;
    do begin
      @(posedge pclk); #1;
      apb_peek(A_STATUS, rd);
      cyc++;
    end while (rd[15:8] != 8'd3 && cyc < 5000);
    check("lb_arrive", 32'(rd[15:8]), 32'd3);
    repeat (60) @(posedge pclk); #1;
    loop_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apb_read(A_DATA, rd);
      check($sformatf("lb_data%0d", i), rd, {24'h0, rx_exp.pop_front()});
    end
    apb_peek(A_STATUS, rd);
    check("lb_status", rd, 32'h0000_000A);

    // RX overrun, div=0
    apb_write(A_CTRL, 32'h0000_0002);
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'(i * 37 + 11);
      if (i < DEPTH) rx_exp.push_back(b);
      send_byte(b, 1'b1, 0, (i == 0) ? 1 : 0);
      repeat (4) @(posedge pclk); #1;
    end
    apb_peek(A_STATUS, rd);
    check("ovr_status", rd, 32'h0000_0826);
    for (int i = 0; i < DEPTH; i++) begin
      apb_read(A_DATA, rd);
      check($sformatf("ovr_data%0d", i), rd, {24'h0, rx_exp.pop_front()});
    end
    apb_read(A_DATA, rd);
    check("empty_read", rd, 32'h0);
    apb_peek(A_STATUS, rd);
    check("ovr_sticky", rd, 32'h0000_002A);
    apb_write(A_STATUS, 32'h0000_0020);
    apb_peek(A_STATUS, rd);
    check("ovr_clear", rd, 32'h0000_000A);

    // Framing error, glitch, then a clean frame
    send_byte(8'h55, 1'b0, 0, 0);
    repeat (8) @(posedge pclk); #1;
    apb_peek(A_STATUS, rd);
    check("frm_status", rd, 32'h0000_004A);
    apb_write(A_STATUS, 32'h0000_0040);
    rx_drv = 1'b0;
    repeat (4) @(posedge pclk); #1;
    rx_drv = 1'b1;
    repeat (30) @(posedge pclk); #1;
    apb_peek(A_STATUS, rd);
    check("glitch_status", rd, 32'h0000_000A);
    rx_exp.push_back(8'h81);
    send_byte(8'h81, 1'b1, 0, 0);
    repeat (4) @(posedge pclk); #1;
    apb_read(A_DATA, rd);
    check("post_glitch_data", rd, {24'h0, rx_exp.pop_front()});

    // Interrupt on RX not-empty
    apb_write(A_IE, 32'h0000_0001);
    check("irq_idle", 32'(uart_irq), 32'd0);
    rx_exp.push_back(8'h5A);
    send_byte(8'h5A, 1'b1, 0, 2);
    apb_read(A_DATA, rd);
    check("irq_data", rd, {24'h0, rx_exp.pop_front()});
    check("irq_hold", 32'(uart_irq), 32'd1);
    @(posedge pclk); #1;
    check("irq_fall", 32'(uart_irq), 32'd0);

    // TX overflow with error interrupt, TX disabled so the FIFO fills
    apb_write(A_CTRL, 32'h0000_0000);
    apb_write(A_IE, 32'h0000_0004);
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'(i * 53 + 7);
      rx_exp.push_back(b);
      apb_write(A_DATA, {24'h0, b});
    end
    apb_peek(A_STATUS, rd);
    check("txf_full", rd, 32'h0000_0009);
    check("txf_irq_quiet", 32'(uart_irq), 32'd0);
    apb_write(A_DATA, 32'h0000_00EE);
    apb_peek(A_STATUS, rd);
    check("ovf_status", rd, 32'h0000_0089);
    check("ovf_irq_lag", 32'(uart_irq), 32'd0);
    @(posedge pclk); #1;
    check("ovf_irq", 32'(uart_irq), 32'd1);
    apb_write(A_STATUS, 32'h0000_0080);
    apb_peek(A_STATUS, rd);
    check("ovf_clear", rd, 32'h0000_0009);
    @(posedge pclk); #1;
    check("ovf_irq_clr", 32'(uart_irq), 32'd0);

    // Drain the full TX FIFO through the loopback; the dropped byte must not appear
    loop_en = 1'b1;
    apb_write(A_CTRL, 32'h0000_0003);
    cyc = 0;
    do begin
      @(posedge pclk); #1;
      apb_peek(A_STATUS, rd);
      cyc++;
    end while (rd[15:8] != 8'(DEPTH) && cyc < 3000);
    check("drain_count", 32'(rd[15:8]), 32'(DEPTH));
    repeat (30) @(posedge pclk); #1;
    loop_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      apb_read(A_DATA, rd);
      check($sformatf("drain_data%0d", i), rd, {24'h0, rx_exp.pop_front()});
    end
    apb_peek(A_STATUS, rd);
    check("drain_status", rd, 32'h0000_000A);

    // Reset in the middle of a frame
    apb_write(A_CTRL, 32'h0000_0001);
    apb_write(A_DATA, 32'h0000_0000);
    cyc = 0;
    while (uart_tx && cyc < 20) begin
      @(posedge pclk); #1;
      cyc++;
    end
    repeat (5) @(posedge pclk); #2;
    check("pre_rst_tx", 32'(uart_tx), 32'd0);
    prstn = 1'b0;
    #1;
    check("async_rst_tx", 32'(uart_tx), 32'd1);
    @(posedge pclk); #1 prstn = 1'b1;
    @(posedge pclk); #1;
    apb_peek(A_STATUS, rd);
    check("rst2_status", rd, 32'h0000_000A);
    apb_peek(A_CTRL, rd);
    check("rst2_ctrl", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
